mem_boot_arbiter: RTL
=====================

Name: mem_boot_arbiter

Overview:
- Owns the single unified instruction/data memory port of the multicycle RISC-V core.
- Shares that port between two requesters: the external preload port (testbench or boot ROM writer) and the core.
- Sequences boot: holds the core in reset while memory is preloaded, then releases it after a fixed delay.
- Supports a mid-run pause so the loader can patch memory, then resumes the core.

Parameters:
- ADDR_W, 32, address width (byte addresses).
- DATA_W, 32, data word width.
- RELEASE_CYCLES, 2, cycles between ld_done and core reset deassertion (range 1..15).
- CNT_W, 16, width of the loaded-word counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_req  in  1  loader write request (one word per granted cycle).
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  DATA_W  loader write data.
- ld_done  in  1  loader finished; level, sampled when ld_req=0.
- ld_gnt  out  1  loader write accepted this cycle.
- ld_err  out  1  sticky; set on a misaligned loader address.
- ld_count  out  CNT_W  number of words written by the loader since reset.
- cpu_mem_en  in  1  core memory access request.
- cpu_we  in  1  core write enable.
- cpu_addr  in  ADDR_W  core byte address.
- cpu_wdata  in  DATA_W  core write data.
- cpu_rdata  out  DATA_W  read data returned to the core.
- cpu_ready  out  1  core access completes this cycle.
- cpu_rst  out  1  active-high reset to the core.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational read).

Behaviour:
- Reset values (rst=0 at a clock edge):
  - State=BOOT; cpu_rst=1; ld_gnt=0; ld_err=0; ld_count=0; cpu_ready=0.
  - mem_we=0; mem_addr=0; mem_wdata=0; cpu_rdata=0; release counter=0.
- States and transitions (registered):
  - BOOT:
    - The loader owns the port; mem_* follow ld_* combinationally and mem_we=ld_req.
    - ld_gnt=ld_req (0-cycle grant); ld_count increments on each grant.
    - ld_done=1 with ld_req=0 -> RELEASE.
    - ld_req and ld_done both high -> the write is granted and the state stays BOOT (ld_req has priority).
  - RELEASE:
    - cpu_rst stays 1; the counter counts up from 0.
    - When the counter reaches RELEASE_CYCLES-1 -> RUN; cpu_rst drops on the same edge.
    - An ld_req in RELEASE -> back to BOOT; the counter clears; the request is granted next cycle.
  - RUN:
    - The core owns the port; mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_mem_en&cpu_we.
    - cpu_rdata=mem_rdata; cpu_ready=cpu_mem_en (combinational).
    - ld_req=1 -> PAUSE at the next edge; the core access in the current cycle still completes.
  - PAUSE:
    - cpu_ready=0 (core stalls; cpu_rst stays 0); the loader owns the port exactly as in BOOT.
    - ld_done=1 with ld_req=0 -> RUN (no release delay).
- Misalignment:
  - A loader address with ld_addr[1:0]!=0 is still granted, but mem_we is forced to 0 and ld_err is set (sticky until reset).
  - ld_count does not increment for that request.
  - Core misalignment is not checked here.
- Width rules:
  - ld_count saturates at all-ones; it does not wrap.
  - The release counter is 4 bits.
- Mid-operation reset: synchronous rst=0 in any state returns to BOOT with all reset values above. An in-flight grant that cycle is dropped (mem_we=0).
- Outside RUN, cpu_rdata is held at 0.

Optional Feature:
- Macro: MEM_BOOT_CHECKSUM_EN.
- With the macro defined:
  - Adds output ld_csum (DATA_W). It is reset to 0 and XOR-accumulates ld_wdata on every aligned granted loader write.
  - It is frozen outside BOOT and PAUSE.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_boot_pkg:
  - state enum (BOOT, RELEASE, RUN, PAUSE);
  - ADDR_W and DATA_W defaults;
  - RELEASE_CNT_W=4.
- One natural sub-module: mem_port_mux. It is the purely combinational selection of the loader or core onto mem_*, driven by a single owner bit.

Test Plan:
- Boot load: hold rst=0 for 2 cycles, then write 10 words (addr 100..136, data 2,3,1,7,4,8,9,4,125,2) and 13 instruction words (addr 0..48) -> ld_gnt=1 each cycle, ld_count=23, cpu_rst=1 throughout.
- Release timing: drop ld_req, assert ld_done with RELEASE_CYCLES=2 -> cpu_rst falls exactly 2 edges later; cpu_ready follows cpu_mem_en from the next cycle.
- Core access: in RUN, cpu read addr 132 -> cpu_rdata=125, cpu_ready=1 the same cycle; a cpu write of 125 to addr 240 -> mem_we=1, mem_addr=240.
- Pause/patch: in RUN, ld_req with addr 104, data 50 -> next cycle PAUSE, cpu_ready=0 while cpu_mem_en=1, write granted; ld_done -> RUN, and a read of 104 returns 50.
- Misaligned/priority: ld_addr=102 -> ld_err=1, mem_we=0, ld_count unchanged; ld_req and ld_done both high in BOOT -> stays BOOT and grants.
- Reset mid-RUN: rst=0 for 1 cycle -> cpu_rst=1, state BOOT, ld_count=0, ld_err=0; with MEM_BOOT_CHECKSUM_EN, writes of 2 and 3 give ld_csum=1.

Source files
------------

// File: rtl/mem_boot_pkg.sv
// Shared types and defaults for the boot/run memory port arbiter.
package mem_boot_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int RELEASE_CNT_W = 4;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    PAUSE   = 2'd3
  } state_e;

  // The loader drives the memory port while the core is held or paused.
  function automatic logic loader_owns(input state_e s);
    return (s == BOOT) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Purely combinational steering of either the loader or the core onto the memory port.
module mem_port_mux
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              owner_cpu,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  always_comb begin
    if (owner_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = ld_we;
    end
  end

endmodule

// File: rtl/mem_boot_arbiter.sv
// Boot sequencer and memory-port arbiter between the preload port and the core.
// Optional loader checksum output ld_csum is enabled by defining MEM_BOOT_CHECKSUM_EN.
module mem_boot_arbiter
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int RELEASE_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic              ld_err,
  output logic [CNT_W-1:0]  ld_count,
`ifdef MEM_BOOT_CHECKSUM_EN
  output logic [DATA_W-1:0] ld_csum,
`endif
  input  logic              cpu_mem_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_rst,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [RELEASE_CNT_W-1:0] REL_LAST = RELEASE_CNT_W'(RELEASE_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [RELEASE_CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic                     cpu_rst_q, cpu_rst_d;
  logic [CNT_W-1:0]         ld_count_q, ld_count_d;
  logic                     ld_err_q, ld_err_d;

  logic              ld_aligned;
  logic              ld_wr;
  logic              core_we;
  logic              owner_cpu;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  assign ld_aligned = (ld_addr[1:0] == 2'b00);
  assign owner_cpu  = (state_q == RUN);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q    <= BOOT;
      rel_cnt_q  <= '0;
      cpu_rst_q  <= 1'b1;
      ld_count_q <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rel_cnt_q  <= rel_cnt_d;
      cpu_rst_q  <= cpu_rst_d;
      ld_count_q <= ld_count_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // Next-state logic; ld_req always wins over ld_done.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      BOOT: begin
        if (!ld_req && ld_done) begin
          state_d   = RELEASE;
          rel_cnt_d = '0;
        end
      end
      RELEASE: begin
        if (ld_req) begin
          state_d   = BOOT;
          rel_cnt_d = '0;
        end else if (rel_cnt_q == REL_LAST) begin
          state_d   = RUN;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (ld_req) state_d = PAUSE;
      end
      PAUSE: begin
        if (!ld_req && ld_done) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
    cpu_rst_d = (state_d == BOOT) || (state_d == RELEASE);
  end

  // Output decode; a low rst suppresses every in-flight grant or access.
  always_comb begin
    ld_gnt    = 1'b0;
    ld_wr     = 1'b0;
    core_we   = 1'b0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    if (rst) begin
      ld_gnt = loader_owns(state_q) && ld_req;
      ld_wr  = ld_gnt && ld_aligned;
      if (owner_cpu) begin
        cpu_ready = cpu_mem_en;
        cpu_rdata = mem_rdata;
        core_we   = cpu_mem_en && cpu_we;
      end
    end
  end

  // Loader bookkeeping; the word count saturates instead of wrapping.
  always_comb begin
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    if (ld_wr && (ld_count_q != {CNT_W{1'b1}})) ld_count_d = ld_count_q + 1'b1;
    if (ld_gnt && !ld_aligned) ld_err_d = 1'b1;
  end

`ifdef MEM_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] ld_csum_q, ld_csum_d;

  always_comb begin
    ld_csum_d = ld_csum_q;
    if (ld_wr) ld_csum_d = ld_csum_q ^ ld_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) ld_csum_q <= '0;
    else      ld_csum_q <= ld_csum_d;
  end

  assign ld_csum = ld_csum_q;
`endif

  mem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .owner_cpu (owner_cpu),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_we     (ld_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (core_we),
    .mem_addr  (mux_addr),
    .mem_wdata (mux_wdata),
    .mem_we    (mem_we)
  );

  assign mem_addr  = rst ? mux_addr  : '0;
  assign mem_wdata = rst ? mux_wdata : '0;
  assign cpu_rst   = cpu_rst_q;
  assign ld_err    = ld_err_q;
  assign ld_count  = ld_count_q;

endmodule
